// File: rtl/lut_gpio_loader_pkg.sv
// Shared GPIO field layout and loader state/byte-select types for the LUT GPIO loader.
package lut_gpio_loader_pkg;

  localparam int unsigned gpio_w         = 32;
  localparam int unsigned gpio_w_clk_bit = 16;
  localparam int unsigned gpio_addr_start = 15;
  localparam int unsigned gpio_addr_end   = 8;
  localparam int unsigned gpio_data_start = 7;
  localparam int unsigned gpio_data_end   = 0;
  localparam int unsigned gpio_addr_w = gpio_addr_start - gpio_addr_end + 1;
  localparam int unsigned gpio_data_w = gpio_data_start - gpio_data_end + 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    GAP,
    FETCH,
    DONE
  } lut_ld_state_t;

  typedef enum logic [1:0] {
    ADDR_H,
    ADDR_L,
    DATA_H,
    DATA_L
  } lut_byte_sel_t;

  // Assemble a GPIO bus word; every bit outside the three fields stays 0.
  function automatic logic [gpio_w-1:0] gpio_word(input logic w_clk,
                                                  input logic [gpio_addr_w-1:0] addr,
                                                  input logic [gpio_data_w-1:0] data);
    logic [gpio_w-1:0] g;
    g = '0;
    g[gpio_w_clk_bit] = w_clk;
    g[gpio_addr_start:gpio_addr_end] = addr;
    g[gpio_data_start:gpio_data_end] = data;
    return g;
  endfunction

endpackage

// File: rtl/gpio_strobe_gen.sv
// Single-byte GPIO write: one setup cycle, PULSE_CYCLES of w_clk high, GAP_CYCLES low.
// ack is high during the last gap cycle so the next byte can start without a bubble.
module gpio_strobe_gen
  import lut_gpio_loader_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [gpio_addr_w-1:0] addr,
  input  logic [gpio_data_w-1:0] data,
  output logic [gpio_w-1:0]      gpio_out,
  output logic                   ack
);

  localparam int unsigned CNT_W = 8;

  lut_ld_state_t    phase;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= IDLE;
      cnt      <= '0;
      gpio_out <= '0;
      ack      <= 1'b0;
    end else if (start) begin
      gpio_out <= gpio_word(1'b0, addr, data);
      phase    <= SETUP;
      cnt      <= '0;
      ack      <= 1'b0;
    end else begin
      case (phase)
        SETUP: begin
          gpio_out[gpio_w_clk_bit] <= 1'b1;
          phase <= STROBE;
          cnt   <= CNT_W'(PULSE_CYCLES - 1);
        end
        STROBE: begin
          if (cnt == '0) begin
            gpio_out[gpio_w_clk_bit] <= 1'b0;
            phase <= GAP;
            cnt   <= CNT_W'(GAP_CYCLES - 1);
            ack   <= (GAP_CYCLES == 1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == '0) begin
            phase <= IDLE;
            ack   <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
            ack <= (cnt == CNT_W'(1));
          end
        end
        default: ack <= 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/lut_gpio_loader.sv
// Bulk loader: turns (base, N words) into address-register then data-register GPIO byte
// writes, high byte first. The LUT auto-increments, so the address is sent once per sequence.
module lut_gpio_loader
  import lut_gpio_loader_pkg::*;
#(
  parameter int unsigned ADDR_REG     = 0,
  parameter int unsigned DATA_REG     = 1,
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_start,
  input  logic [15:0]       cmd_base_addr,
  input  logic [15:0]       cmd_len,
  input  logic [15:0]       wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [gpio_w-1:0] gpio_out,
  output logic              busy,
  output logic              done,
  output logic [15:0]       words_written
);

  lut_ld_state_t state;
  lut_byte_sel_t byte_sel;
  logic [15:0]   base_q;
  logic [15:0]   len_q;
  logic [15:0]   word_q;
  logic          ack;

  logic                   start_c;
  logic [gpio_addr_w-1:0] st_addr_c;
  logic [gpio_data_w-1:0] st_data_c;

  // Launch the next byte in the same cycle the decision is made so bytes run back to back.
  always_comb begin
    start_c   = 1'b0;
    st_addr_c = gpio_addr_w'(ADDR_REG);
    st_data_c = base_q[15:8];
    case (state)
      IDLE: begin
        if (cmd_start) begin
          start_c   = 1'b1;
          st_data_c = cmd_base_addr[15:8];
        end
      end
      SETUP: begin
        if (ack && byte_sel == ADDR_H) begin
          start_c   = 1'b1;
          st_data_c = base_q[7:0];
        end else if (ack && byte_sel == DATA_H) begin
          start_c   = 1'b1;
          st_addr_c = gpio_addr_w'(DATA_REG);
          st_data_c = word_q[7:0];
        end
      end
      FETCH: begin
        if (wr_valid && wr_ready) begin
          start_c   = 1'b1;
          st_addr_c = gpio_addr_w'(DATA_REG);
          st_data_c = wr_data[15:8];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      byte_sel      <= ADDR_H;
      base_q        <= '0;
      len_q         <= '0;
      word_q        <= '0;
      wr_ready      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      words_written <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (cmd_start) begin
            base_q        <= cmd_base_addr;
            len_q         <= cmd_len;
            words_written <= '0;
            busy          <= 1'b1;
            byte_sel      <= ADDR_H;
            state         <= SETUP;
          end
        end
        SETUP: begin
          if (ack) begin
            case (byte_sel)
              ADDR_H: byte_sel <= ADDR_L;
              ADDR_L: begin
                if (len_q == '0) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  state    <= FETCH;
                  wr_ready <= 1'b1;
                end
              end
              DATA_H: byte_sel <= DATA_L;
              DATA_L: begin
                words_written <= words_written + 16'd1;
                if ((words_written + 16'd1) == len_q) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  state    <= FETCH;
                  wr_ready <= 1'b1;
                end
              end
            endcase
          end
        end
        FETCH: begin
          if (wr_valid && wr_ready) begin
            word_q   <= wr_data;
            byte_sel <= DATA_H;
            wr_ready <= 1'b0;
            state    <= SETUP;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  gpio_strobe_gen #(
    .PULSE_CYCLES(PULSE_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES)
  ) u_strobe (
    .clk     (clk),
    .rst     (rst),
    .start   (start_c),
    .addr    (st_addr_c),
    .data    (st_data_c),
    .gpio_out(gpio_out),
    .ack     (ack)
  );

endmodule

// File: tb/tb_lut_gpio_loader.sv
// Directed bench: three loaders (P/G = 2/2, 1/1, 4/3) share one stimulus; a small LUT
// model decodes each GPIO bus and directed steps check timing, strobe order and contents.
module tb_lut_gpio_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_start;
  logic [15:0] cmd_base_addr;
  logic [15:0] cmd_len;
  logic        wr_valid;

  logic [31:0] gpio     [3];
  logic        busy     [3];
  logic        done     [3];
  logic        wr_ready [3];
  logic [15:0] ww       [3];
  logic [15:0] wr_data  [3];
  logic [1:0]  idx      [3];

  logic [15:0] words [4] = '{16'hABCD, 16'h0102, 16'h0000, 16'h0000};
  int pw [3] = '{2, 1, 4};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign wr_data[0] = words[idx[0]];
  assign wr_data[1] = words[idx[1]];
  assign wr_data[2] = words[idx[2]];

  lut_gpio_loader #(.ADDR_REG(0), .DATA_REG(1), .PULSE_CYCLES(2), .GAP_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_base_addr(cmd_base_addr),
    .cmd_len(cmd_len), .wr_data(wr_data[0]), .wr_valid(wr_valid), .wr_ready(wr_ready[0]),
    .gpio_out(gpio[0]), .busy(busy[0]), .done(done[0]), .words_written(ww[0]));

  lut_gpio_loader #(.ADDR_REG(0), .DATA_REG(1), .PULSE_CYCLES(1), .GAP_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_base_addr(cmd_base_addr),
    .cmd_len(cmd_len), .wr_data(wr_data[1]), .wr_valid(wr_valid), .wr_ready(wr_ready[1]),
    .gpio_out(gpio[1]), .busy(busy[1]), .done(done[1]), .words_written(ww[1]));

  lut_gpio_loader #(.ADDR_REG(0), .DATA_REG(1), .PULSE_CYCLES(4), .GAP_CYCLES(3)) dut2 (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_base_addr(cmd_base_addr),
    .cmd_len(cmd_len), .wr_data(wr_data[2]), .wr_valid(wr_valid), .wr_ready(wr_ready[2]),
    .gpio_out(gpio[2]), .busy(busy[2]), .done(done[2]), .words_written(ww[2]));

  // Word stream source per loader: advance on each accepted word.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (cmd_start && !busy[i]) idx[i] <= 2'd0;
      else if (wr_valid && wr_ready[i]) idx[i] <= idx[i] + 2'd1;
    end
  end

  // Bus monitor and LUT model (address toggle hi/lo, data toggle hi/lo, auto-increment).
  logic        prev_w   [3];
  logic        at_q     [3];
  logic        dt_q     [3];
  logic [7:0]  dhi      [3];
  logic [15:0] ptr      [3];
  logic [15:0] rise_f   [3];
  int hi_len [3], lo_len [3], lo_min [3], lo_max [3];
  int width_err [3], field_err [3], strobes [3], busy_cnt [3], done_cnt [3];
  logic [15:0] slog [$];
  logic [15:0] lut [logic [17:0]];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        prev_w[i] = 1'b0;
        at_q[i]   = 1'b0;
        dt_q[i]   = 1'b0;
      end else begin
        if (busy[i]) busy_cnt[i]++;
        if (done[i]) done_cnt[i]++;
        if (gpio[i][31:17] != 15'd0) field_err[i]++;
        if (gpio[i][16] && !prev_w[i]) begin
          if (strobes[i] > 0) begin
            if (lo_len[i] < lo_min[i]) lo_min[i] = lo_len[i];
            if (lo_len[i] > lo_max[i]) lo_max[i] = lo_len[i];
          end
          strobes[i]++;
          hi_len[i] = 1;
          rise_f[i] = gpio[i][15:0];
          if (i == 0) slog.push_back(gpio[i][15:0]);
          if (gpio[i][15:8] == 8'h00) begin
            if (!at_q[i]) ptr[i][15:8] = gpio[i][7:0];
            else ptr[i][7:0] = gpio[i][7:0];
            at_q[i] = ~at_q[i];
          end else if (gpio[i][15:8] == 8'h01) begin
            if (!dt_q[i]) dhi[i] = gpio[i][7:0];
            else begin
              lut[{i[1:0], ptr[i]}] = {dhi[i], gpio[i][7:0]};
              ptr[i] = ptr[i] + 16'd1;
            end
            dt_q[i] = ~dt_q[i];
          end
        end else if (gpio[i][16]) begin
          hi_len[i]++;
          if (gpio[i][15:0] != rise_f[i]) field_err[i]++;
        end else if (prev_w[i]) begin
          if (hi_len[i] != pw[i]) width_err[i]++;
          if (gpio[i][15:0] != rise_f[i]) field_err[i]++;
          lo_len[i] = 1;
        end else begin
          lo_len[i]++;
        end
        prev_w[i] = gpio[i][16];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lut_rd(input logic [1:0] inst, input logic [15:0] a);
    if (lut.exists({inst, a})) return {16'h0000, lut[{inst, a}]};
    return 32'hFFFF_FFFF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 3; i++) begin
      busy_cnt[i] = 0; done_cnt[i] = 0; strobes[i] = 0;
      width_err[i] = 0; field_err[i] = 0; lo_min[i] = 1000; lo_max[i] = 0;
    end
    slog.delete();
    lut.delete();
  endtask

  task automatic start_seq(input logic [15:0] base, input logic [15:0] len);
    cmd_base_addr = base;
    cmd_len       = len;
    cmd_start     = 1'b1;
    tick();
    cmd_start     = 1'b0;
  endtask

  task automatic wait_all_done(input string tag);
    int t;
    t = 0;
    while ((done_cnt[0] < 1 || done_cnt[1] < 1 || done_cnt[2] < 1) && t < 400) begin
      tick();
      t++;
    end
    chk(tag, 32'(t < 400), 32'd1);
    repeat (5) tick();
  endtask

  initial begin
    int t;
    rst = 1'b1; cmd_start = 1'b0; wr_valid = 1'b0;
    cmd_base_addr = 16'h0000; cmd_len = 16'h0000;
    clear_mon();
    repeat (3) tick();
    chk("rst_gpio", gpio[0], 32'h0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_done", 32'(done[0]), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready[0]), 32'd0);
    chk("rst_words", 32'(ww[0]), 32'd0);
    rst = 1'b0;
    tick();

    // Address-only sequence
    clear_mon();
    start_seq(16'h1234, 16'd0);
    wait_all_done("ao_timeout");
    chk("ao_busy0", 32'(busy_cnt[0]), 32'd10);
    chk("ao_busy1", 32'(busy_cnt[1]), 32'd6);
    chk("ao_busy2", 32'(busy_cnt[2]), 32'd16);
    chk("ao_nstrobe", 32'(slog.size()), 32'd2);
    chk("ao_s0", 32'(slog[0]), 32'h0012);
    chk("ao_s1", 32'(slog[1]), 32'h0034);
    chk("ao_done", 32'(done_cnt[0]), 32'd1);
    chk("ao_words", 32'(ww[0]), 32'd0);
    chk("ao_hold", gpio[0], 32'h0000_0034);

    // Two-word load, stream always valid
    clear_mon();
    wr_valid = 1'b1;
    start_seq(16'h1234, 16'd2);
    wait_all_done("tw_timeout");
    wr_valid = 1'b0;
    chk("tw_busy0", 32'(busy_cnt[0]), 32'd32);
    chk("tw_busy1", 32'(busy_cnt[1]), 32'd20);
    chk("tw_busy2", 32'(busy_cnt[2]), 32'd50);
    chk("tw_nstrobe", 32'(slog.size()), 32'd6);
    chk("tw_s0", 32'(slog[0]), 32'h0012);
    chk("tw_s1", 32'(slog[1]), 32'h0034);
    chk("tw_s2", 32'(slog[2]), 32'h01AB);
    chk("tw_s3", 32'(slog[3]), 32'h01CD);
    chk("tw_s4", 32'(slog[4]), 32'h0101);
    chk("tw_s5", 32'(slog[5]), 32'h0102);
    chk("tw_words0", 32'(ww[0]), 32'd2);
    chk("tw_words2", 32'(ww[2]), 32'd2);
    chk("tw_lut0_a", lut_rd(2'd0, 16'h1234), 32'h0000_ABCD);
    chk("tw_lut0_b", lut_rd(2'd0, 16'h1235), 32'h0000_0102);
    chk("tw_lut1_a", lut_rd(2'd1, 16'h1234), 32'h0000_ABCD);
    chk("tw_lut1_b", lut_rd(2'd1, 16'h1235), 32'h0000_0102);
    chk("tw_lut2_a", lut_rd(2'd2, 16'h1234), 32'h0000_ABCD);
    chk("tw_lut2_b", lut_rd(2'd2, 16'h1235), 32'h0000_0102);
    chk("sw_width0", 32'(width_err[0]), 32'd0);
    chk("sw_width1", 32'(width_err[1]), 32'd0);
    chk("sw_width2", 32'(width_err[2]), 32'd0);
    chk("sw_field0", 32'(field_err[0]), 32'd0);
    chk("sw_field1", 32'(field_err[1]), 32'd0);
    chk("sw_field2", 32'(field_err[2]), 32'd0);
    chk("sw_gapmin1", 32'(lo_min[1]), 32'd2);
    chk("sw_gapmax1", 32'(lo_max[1]), 32'd3);
    chk("sw_gapmin2", 32'(lo_min[2]), 32'd4);
    chk("sw_gapmax2", 32'(lo_max[2]), 32'd5);

    // Stream stall of 7 cycles before word 2
    clear_mon();
    wr_valid = 1'b1;
    start_seq(16'h1234, 16'd2);
    t = 0;
    while (idx[0] != 2'd1 && t < 100) begin tick(); t++; end
    chk("st_w0_timeout", 32'(t < 100), 32'd1);
    wr_valid = 1'b0;
    t = 0;
    while (wr_ready[0] != 1'b1 && t < 100) begin tick(); t++; end
    chk("st_fetch_timeout", 32'(t < 100), 32'd1);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("st_hold", gpio[0], 32'h0000_01CD);
      chk("st_ready", 32'(wr_ready[0]), 32'd1);
    end
    wr_valid = 1'b1;
    wait_all_done("st_timeout");
    wr_valid = 1'b0;
    chk("st_busy0", 32'(busy_cnt[0]), 32'd39);
    chk("st_nstrobe", 32'(slog.size()), 32'd6);
    chk("st_words0", 32'(ww[0]), 32'd2);
    chk("st_lut0_a", lut_rd(2'd0, 16'h1234), 32'h0000_ABCD);
    chk("st_lut0_b", lut_rd(2'd0, 16'h1235), 32'h0000_0102);
    chk("st_field0", 32'(field_err[0]), 32'd0);

    // cmd_start while busy must be ignored
    clear_mon();
    wr_valid = 1'b1;
    start_seq(16'h1234, 16'd2);
    repeat (12) tick();
    start_seq(16'h0000, 16'd5);
    wait_all_done("bp_timeout");
    wr_valid = 1'b0;
    chk("bp_done0", 32'(done_cnt[0]), 32'd1);
    chk("bp_done1", 32'(done_cnt[1]), 32'd1);
    chk("bp_done2", 32'(done_cnt[2]), 32'd1);
    chk("bp_busy0", 32'(busy_cnt[0]), 32'd32);
    chk("bp_words0", 32'(ww[0]), 32'd2);
    chk("bp_words1", 32'(ww[1]), 32'd2);
    chk("bp_s0", 32'(slog[0]), 32'h0012);
    chk("bp_lut0_a", lut_rd(2'd0, 16'h1234), 32'h0000_ABCD);
    chk("bp_lut0_b", lut_rd(2'd0, 16'h1235), 32'h0000_0102);
    chk("bp_lut0_zero", 32'(lut.exists(18'h00000)), 32'd0);

    // Reset asserted in the middle of a strobe
    clear_mon();
    wr_valid = 1'b1;
    start_seq(16'h1234, 16'd2);
    t = 0;
    while (gpio[0][16] != 1'b1 && t < 100) begin tick(); t++; end
    chk("mr_strobe_timeout", 32'(t < 100), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mr_gpio", gpio[0], 32'h0);
    chk("mr_busy", 32'(busy[0]), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_valid = 1'b0;
    tick();
    chk("mr_ready", 32'(wr_ready[0]), 32'd0);
    chk("mr_gpio_after", gpio[0], 32'h0);
    chk("mr_words", 32'(ww[0]), 32'd0);
    repeat (3) tick();
    chk("mr_idle_busy", 32'(busy[0]), 32'd0);

    // Address-only sequence after reset
    clear_mon();
    start_seq(16'hBEEF, 16'd0);
    wait_all_done("pr_timeout");
    chk("pr_busy0", 32'(busy_cnt[0]), 32'd10);
    chk("pr_s0", 32'(slog[0]), 32'h00BE);
    chk("pr_s1", 32'(slog[1]), 32'h00EF);
    chk("pr_done", 32'(done_cnt[0]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
